// File: rtl/line_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_pkg
// Description : Shared definitions for the line drawing path. Holds the
//               per-axis direction codes (also used by draw_line), default
//               framebuffer geometry and the pixel writer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package line_pkg;

    // Per-axis step codes; 2'b11 is not emitted and is treated as hold.
    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_INC  = 2'b01;
    localparam logic [1:0] DIR_DEC  = 2'b10;

    // Default framebuffer geometry.
    localparam int DEF_FB_W    = 160;
    localparam int DEF_FB_H    = 120;
    localparam int DEF_ADDR_W  = 15;
    localparam int DEF_COLOR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_RUN    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Apply one direction code to an 8-bit coordinate (wraps modulo 256).
    function automatic logic [7:0] step_coord(input logic [7:0] c, input logic [1:0] d);
        case (d)
            DIR_INC:  return c + 8'd1;
            DIR_DEC:  return c - 8'd1;
            DIR_HOLD: return c;
            default:  return c;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_fifo.sv
`default_nettype none
// ============================================================================
// Module      : step_fifo
// Description : Small synchronous FIFO holding {dirx,diry} step codes between
//               the draw_line stepper and the pixel writer. Show-ahead read:
//               o_rd_data is the head entry whenever o_empty is low.
// Ports       : clk, rst (async, active-low)
//               i_wr_en/i_wr_data  push side (ignored when full)
//               i_rd_en/o_rd_data  pop side (ignored when empty)
//               o_full, o_empty    occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module step_fifo #(
    parameter int DEPTH = 4,   // power of two
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_wr;
    logic w_rd;

    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : line_pixel_writer
// Description : Consumes draw_line step codes, walks a pixel cursor from a
//               latched start point and issues one framebuffer write per
//               visited on-screen pixel over a req/gnt handshake. Off-screen
//               pixels are counted instead of written.
// Ports       : clk, rst (async, active-low)
//               i_start, i_start_x, i_start_y, i_color   line setup
//               i_step_valid, i_dirx, i_diry, i_line_done  stepper side
//               o_step_ready                              stepper enable
//               o_fb_req, o_fb_addr, o_fb_data, i_fb_gnt  framebuffer write
//               o_busy, o_done, o_clip_cnt                status
// Revision    : 1.0 - initial release
// ============================================================================
module line_pixel_writer
    import line_pkg::*;
#(
    parameter int FB_W       = DEF_FB_W,
    parameter int FB_H       = DEF_FB_H,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int COLOR_W    = DEF_COLOR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [7:0]         i_start_x,
    input  logic [7:0]         i_start_y,
    input  logic [COLOR_W-1:0] i_color,
    input  logic               i_step_valid,
    input  logic [1:0]         i_dirx,
    input  logic [1:0]         i_diry,
    input  logic               i_line_done,
    output logic               o_step_ready,
    output logic               o_fb_req,
    output logic [ADDR_W-1:0]  o_fb_addr,
    output logic [COLOR_W-1:0] o_fb_data,
    input  logic               i_fb_gnt,
    output logic               o_busy,
    output logic               o_done,
    output logic [7:0]         o_clip_cnt
);

    localparam logic [ADDR_W:0] C_FB_W = (ADDR_W + 1)'(FB_W);
    localparam logic [ADDR_W:0] C_FB_H = (ADDR_W + 1)'(FB_H);

    state_t             r_state;
    logic [7:0]         r_x;
    logic [7:0]         r_y;
    logic [COLOR_W-1:0] r_color;
    logic               r_fb_req;
    logic [ADDR_W-1:0]  r_fb_addr;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_clip_cnt;
    logic               r_line_done;

    logic               w_full;
    logic               w_empty;
    logic [3:0]         w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_pending;
    logic               w_plot;
    logic               w_on_screen;
    logic               w_finish;
    logic [7:0]         w_nx;
    logic [7:0]         w_ny;
    logic [7:0]         w_px;
    logic [7:0]         w_py;
    logic [ADDR_W:0]    w_px_ext;
    logic [ADDR_W:0]    w_py_ext;
    logic [ADDR_W:0]    w_addr_full;

    assign o_step_ready = (r_state == ST_RUN) & ~w_full;
    assign o_fb_req     = r_fb_req;
    assign o_fb_addr    = r_fb_addr;
    assign o_fb_data    = r_color;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_clip_cnt   = r_clip_cnt;

    // A write is pending while requested and not granted this cycle; a grant
    // in the current cycle frees the port for the next pixel immediately.
    assign w_pending = r_fb_req & ~i_fb_gnt;
    assign w_push    = i_step_valid & o_step_ready;
    assign w_pop     = (r_state == ST_RUN) & ~w_empty & ~w_pending;

    step_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_step_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data ({i_dirx, i_diry}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_nx = step_coord(r_x, w_head[3:2]);
    assign w_ny = step_coord(r_y, w_head[1:0]);

    // FIRST plots the latched start point; RUN plots the freshly stepped one.
    assign w_plot = (r_state == ST_FIRST) | w_pop;
    assign w_px   = (r_state == ST_FIRST) ? r_x : w_nx;
    assign w_py   = (r_state == ST_FIRST) ? r_y : w_ny;

    assign w_px_ext    = (ADDR_W + 1)'(w_px);
    assign w_py_ext    = (ADDR_W + 1)'(w_py);
    assign w_addr_full = w_py_ext * C_FB_W + w_px_ext;

    // The carry bit rejects any pixel whose address would not fit ADDR_W,
    // which only matters for oversized geometry parameters.
    assign w_on_screen = (w_px_ext < C_FB_W) & (w_py_ext < C_FB_H) & ~w_addr_full[ADDR_W];

    // line_done may arrive in the same cycle as the last step push, so the
    // FIFO must stay empty through this cycle before finishing.
    assign w_finish = (r_line_done | i_line_done) & w_empty & ~w_push & ~w_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_color     <= '0;
            r_fb_req    <= 1'b0;
            r_fb_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clip_cnt  <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_fb_req && i_fb_gnt) begin
                r_fb_req <= 1'b0;
            end

            if (w_plot) begin
                if (w_on_screen) begin
                    r_fb_req  <= 1'b1;
                    r_fb_addr <= w_addr_full[ADDR_W-1:0];
                end else if (r_clip_cnt != 8'hFF) begin
                    r_clip_cnt <= r_clip_cnt + 8'd1;
                end
            end

            if (w_pop) begin
                r_x <= w_nx;
                r_y <= w_ny;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_x         <= i_start_x;
                        r_y         <= i_start_y;
                        r_color     <= i_color;
                        r_clip_cnt  <= '0;
                        r_line_done <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_FIRST;
                    end
                end
                ST_FIRST: begin
                    if (i_line_done) begin
                        r_line_done <= 1'b1;
                    end
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_line_done) begin
                        r_line_done <= 1'b1;
                    end
                    if (w_finish) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_pixel_writer
// Description : Self-checking bench for line_pixel_writer. Expected writes
//               are queued as each line is set up and popped on every
//               req/gnt handshake; line setups come from a vector table,
//               stall, reset and restart cases are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_pixel_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  sx;
    logic [7:0]  sy;
    logic [11:0] col;
    logic        step_valid;
    logic [1:0]  dirx;
    logic [1:0]  diry;
    logic        line_done;
    logic        step_ready;
    logic        fb_req;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_gnt;
    logic        busy;
    logic        done;
    logic [7:0]  clip_cnt;

    int checks;
    int errors;
    int done_cnt;
    int gnt_mode;   // -1: never grant, 0: always grant, n>0: every n-th cycle
    int cyc;

    typedef struct packed {
        logic [14:0] a;
        logic [11:0] d;
    } wr_t;
    wr_t q[$];

    logic        pend;
    logic [14:0] pend_addr;

    typedef struct {
        logic [7:0]        sx;
        logic [7:0]        sy;
        logic [11:0]       col;
        int                n_steps;
        logic [0:5][3:0]   st;
        int                gmode;
        int                n_wr;
        logic [0:5][14:0]  wr;
        logic [7:0]        clip;
    } vec_t;
    vec_t tbl [4];

    line_pixel_writer dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_start_x    (sx),
        .i_start_y    (sy),
        .i_color      (col),
        .i_step_valid (step_valid),
        .i_dirx       (dirx),
        .i_diry       (diry),
        .i_line_done  (line_done),
        .o_step_ready (step_ready),
        .o_fb_req     (fb_req),
        .o_fb_addr    (fb_addr),
        .o_fb_data    (fb_data),
        .i_fb_gnt     (fb_gnt),
        .o_busy       (busy),
        .o_done       (done),
        .o_clip_cnt   (clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Handshake monitor: pops the scoreboard and checks request stability.
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("req_held", {16'd0, fb_req, fb_addr}, {16'd0, 1'b1, pend_addr});
                end
                if (fb_req && fb_gnt) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %0d data %0h", fb_addr, fb_data);
                    end else begin
                        e = q.pop_front();
                        if (fb_addr !== e.a || fb_data !== e.d) begin
                            errors++;
                            $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                                     fb_addr, fb_data, e.a, e.d);
                        end
                    end
                end
                if (done) done_cnt++;
                pend      = fb_req && !fb_gnt;
                pend_addr = fb_addr;
            end
        end
    endtask

    task automatic gnt_driver();
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (gnt_mode < 0)       fb_gnt = 1'b0;
            else if (gnt_mode == 0) fb_gnt = 1'b1;
            else                    fb_gnt = ((cyc % gnt_mode) == 0);
        end
    endtask

    // All tasks below are entered and left 1 time unit after a rising edge.
    task automatic do_start(input logic [7:0] x, input logic [7:0] y, input logic [11:0] c);
        done_cnt = 0;
        start = 1'b1; sx = x; sy = y; col = c;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_cycle1", {31'd0, busy}, 32'd1);
        chk("req_cycle1", {31'd0, fb_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("req_cycle2", {31'd0, fb_req}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic drive_step(input logic [3:0] s);
        logic acc;
        acc = 1'b0;
        step_valid = 1'b1;
        {dirx, diry} = s;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = step_ready;
            @(posedge clk); #1;
        end
        step_valid = 1'b0;
        chk("step_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic finish_line(input logic [7:0] exp_clip);
        logic got;
        got = 1'b0;
        line_done = 1'b1;
        @(posedge clk); #1;
        line_done = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = done;
            @(posedge clk); #1;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            chk("clip_cnt", {24'd0, clip_cnt}, {24'd0, exp_clip});
            chk("busy_at_end", {31'd0, busy}, 32'd0);
            chk("queue_drained", q.size(), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt, 32'd1);
    endtask

    initial begin
        int acc;
        checks = 0; errors = 0; done_cnt = 0; cyc = 0; gnt_mode = 0;
        rst = 1'b0; start = 1'b0; sx = '0; sy = '0; col = '0;
        step_valid = 1'b0; dirx = '0; diry = '0; line_done = 1'b0; fb_gnt = 1'b1;
        pend = 1'b0; pend_addr = '0;

        tbl[0] = '{sx: 8'd20, sy: 8'd25, col: 12'hABC, n_steps: 5,
                   st: {4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h0}, gmode: 0, n_wr: 6,
                   wr: {15'd4020, 15'd4181, 15'd4342, 15'd4503, 15'd4664, 15'd4825}, clip: 8'd0};
        tbl[1] = '{sx: 8'd30, sy: 8'd30, col: 12'h123, n_steps: 3,
                   st: {4'hA, 4'hA, 4'h2, 4'h0, 4'h0, 4'h0}, gmode: 3, n_wr: 4,
                   wr: {15'd4830, 15'd4669, 15'd4508, 15'd4348, 15'd0, 15'd0}, clip: 8'd0};
        tbl[2] = '{sx: 8'd0, sy: 8'd5, col: 12'hF0F, n_steps: 1,
                   st: {4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}, gmode: 0, n_wr: 1,
                   wr: {15'd800, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0}, clip: 8'd1};
        tbl[3] = '{sx: 8'd159, sy: 8'd119, col: 12'h777, n_steps: 2,
                   st: {4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0}, gmode: 2, n_wr: 1,
                   wr: {15'd19199, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0}, clip: 8'd2};

        fork
            monitor();
            gnt_driver();
            begin
                #500000;
                $display("FAIL watchdog: simulation did not complete");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state.
        @(negedge clk);
        chk("rst_step_ready", {31'd0, step_ready}, 32'd0);
        chk("rst_fb_req", {31'd0, fb_req}, 32'd0);
        chk("rst_fb_addr", {17'd0, fb_addr}, 32'd0);
        chk("rst_fb_data", {20'd0, fb_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_clip_cnt", {24'd0, clip_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven lines.
        for (int t = 0; t < 4; t++) begin
            gnt_mode = tbl[t].gmode;
            for (int i = 0; i < tbl[t].n_wr; i++) q.push_back('{a: tbl[t].wr[i], d: tbl[t].col});
            do_start(tbl[t].sx, tbl[t].sy, tbl[t].col);
            for (int i = 0; i < tbl[t].n_steps; i++) drive_step(tbl[t].st[i]);
            finish_line(tbl[t].clip);
        end

        // FIFO fills while the framebuffer never grants.
        gnt_mode = -1;
        q.push_back('{a: 15'd9660, d: 12'h0F0});
        do_start(8'd60, 8'd60, 12'h0F0);
        acc = 0;
        step_valid = 1'b1;
        {dirx, diry} = 4'h4;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (step_ready) begin
                acc++;
                q.push_back('{a: 15'(9660 + acc), d: 12'h0F0});
            end
            @(posedge clk); #1;
        end
        step_valid = 1'b0;
        chk("full_accepts", acc, 32'd4);
        @(negedge clk);
        chk("ready_low_full", {31'd0, step_ready}, 32'd0);
        @(posedge clk); #1;
        gnt_mode = 0;
        finish_line(8'd0);

        // A second start during RUN must be ignored.
        gnt_mode = 0;
        q.push_back('{a: 15'd6440, d: 12'h5A5});
        q.push_back('{a: 15'd6441, d: 12'h5A5});
        q.push_back('{a: 15'd6442, d: 12'h5A5});
        do_start(8'd40, 8'd40, 12'h5A5);
        drive_step(4'h4);
        start = 1'b1; sx = 8'd1; sy = 8'd1; col = 12'h000;
        @(posedge clk); #1;
        start = 1'b0;
        drive_step(4'h4);
        finish_line(8'd0);

        // Reset mid-line with a write outstanding.
        gnt_mode = -1;
        q.push_back('{a: 15'd8050, d: 12'h333});
        do_start(8'd50, 8'd50, 12'h333);
        drive_step(4'h4);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, fb_req}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_ready", {31'd0, step_ready}, 32'd0);
        q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        gnt_mode = 0;
        @(posedge clk); #1;
        q.push_back('{a: 15'd1610, d: 12'h444});
        do_start(8'd10, 8'd10, 12'h444);
        finish_line(8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_pixel_writer.md
Name: line_pixel_writer

Overview:
- Downstream consumer of the draw_line stepper.
- Latches a start point and colour, then takes per-step direction codes (dirx/diry) from draw_line and advances a current-pixel cursor.
- Issues one framebuffer write per visited pixel over a request/grant handshake; a small step FIFO absorbs framebuffer stalls.
- step_ready drives draw_line's enable, so the stepper pauses when the FIFO is full.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- ADDR_W, 15, framebuffer address width (FB_W*FB_H must be <= 2**ADDR_W)
- COLOR_W, 12, pixel colour width
- FIFO_DEPTH, 4, step FIFO entries (power of two)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; latches start_x, start_y, color; ignored unless IDLE
- start_x  in  8  line start x
- start_y  in  8  line start y
- color  in  COLOR_W  pixel colour for the whole line
- step_valid  in  1  a dirx/diry step is presented this cycle
- dirx  in  2  x step code: 00 hold, 01 +1, 10 -1, 11 treated as hold
- diry  in  2  y step code, same encoding
- line_done  in  1  draw_line done; no further steps follow
- step_ready  out  1  FIFO not full and state is RUN; connect to draw_line enable
- fb_req  out  1  framebuffer write request
- fb_addr  out  ADDR_W  y*FB_W + x
- fb_data  out  COLOR_W  latched colour
- fb_gnt  in  1  write accepted this cycle
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the line is complete
- clip_cnt  out  8  pixels suppressed as off-screen in the current line (saturates at 255)

Behaviour:
- Reset values (all outputs): step_ready 0, fb_req 0, fb_addr 0, fb_data 0, busy 0, done 0, clip_cnt 0. FIFO empty; state IDLE; cursor (0,0).
- States: IDLE, FIRST, RUN, FINISH.
- IDLE:
  - start=1 → load cursor=(start_x,start_y), latch colour, clear clip_cnt and the sticky line_done flag, go to FIRST.
- FIRST: plot the start pixel, then go to RUN.
- Plotting a pixel:
  - If x<FB_W and y<FB_H: assert fb_req with fb_addr/fb_data. Hold them stable until the cycle where fb_gnt=1; fb_req drops the next cycle unless another write is issued immediately.
  - Otherwise: no request; clip_cnt increments.
  - Only one write is outstanding at a time. Address arithmetic is computed at ADDR_W+1 bits.
- RUN:
  - A step is pushed when step_valid && step_ready. step_ready is low outside RUN.
  - A step is popped only when no write is pending. The cursor is updated with 8-bit wrap (0 with -1 → 255, which is then clipped).
  - The new pixel is plotted in the cycle after the pop. Throughput is 1 pixel/cycle when fb_gnt is held high.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
- line_done: captured into a sticky flag. When the flag is set, the FIFO is empty and no write is pending → FINISH.
- FINISH: done=1 for exactly one cycle, busy falls, return to IDLE.
- Hold codes: a step of (00,00) or code 11 still re-plots the current pixel (draw_line never emits one).
- start while busy: ignored.
- Reset mid-line: all state cleared asynchronously. fb_req drops immediately; the in-flight write is abandoned.
- Latency: start → first fb_req is 2 cycles. Step push → its fb_req is 2 cycles minimum.

Decomposition:
- Shared package (line_pkg): DIR_HOLD/DIR_INC/DIR_DEC codes, FB_W/FB_H/ADDR_W/COLOR_W defaults, state encoding. draw_line uses the same direction constants.
- One sub-module: step_fifo, a synchronous FIFO of 4-bit {dirx,diry} entries with full/empty, parameterised by depth, async active-low reset.

Test Plan:
- Start (20,25), steps 5×(01,01), fb_gnt tied 1, line_done after the last step → addresses 4020,4181,4342,4503,4664,4825; done once; clip_cnt 0.
- Start (30,30), steps (10,10),(10,10),(00,10) with fb_gnt high only every 3rd cycle → addresses 4830,4669,4508,4348 in order; fb_addr stable while ungranted; step_ready low while the FIFO is full.
- Start (0,5), step (10,00) → x wraps to 255; no fb_req for that pixel; clip_cnt=1; done still pulses.
- Start (159,119), steps (01,00),(00,01) → 19199 written, then 2 clipped; clip_cnt=2.
- Reset asserted (rst=0) while fb_req=1 mid-line → fb_req, busy, step_ready are 0 asynchronously. The next start (10,10) writes 1610 first.
- Second start pulse during RUN → ignored; cursor and colour unchanged; exactly one done pulse per line.
